// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - EX-side trap/CSR bundle between the pipeline and trap_controller
interface trap_controller_if #(
  parameter int XLEN = 32
);
  // EX-stage event report
  logic            i_ex_valid;
  logic [XLEN-1:0] i_ex_pc;
  logic            i_exception_valid;
  logic [XLEN-1:0] i_exception_cause;
  logic [XLEN-1:0] i_exception_tval;
  logic            i_is_mret;
  // interrupt sources and enables
  logic            i_meip;
  logic            i_msip;
  logic            i_mtip;
  logic [XLEN-1:0] i_mie;
  logic [XLEN-1:0] i_mtvec;
  // CSR write port
  logic            i_csr_we;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_wdata;
  // CSR read values
  logic [XLEN-1:0] o_mepc;
  logic [XLEN-1:0] o_mcause;
  logic [XLEN-1:0] o_mtval;
  logic [XLEN-1:0] o_mstatus;
  // pipeline control
  logic            o_flush;
  logic            o_stall;
  logic            o_redirect_valid;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_trap_taken;

  modport master (
    output i_ex_valid, i_ex_pc, i_exception_valid, i_exception_cause, i_exception_tval,
    output i_is_mret, i_meip, i_msip, i_mtip, i_mie, i_mtvec,
    output i_csr_we, i_csr_addr, i_csr_wdata,
    input  o_mepc, o_mcause, o_mtval, o_mstatus,
    input  o_flush, o_stall, o_redirect_valid, o_redirect_pc, o_trap_taken
  );

  modport slave (
    input  i_ex_valid, i_ex_pc, i_exception_valid, i_exception_cause, i_exception_tval,
    input  i_is_mret, i_meip, i_msip, i_mtip, i_mie, i_mtvec,
    input  i_csr_we, i_csr_addr, i_csr_wdata,
    output o_mepc, o_mcause, o_mtval, o_mstatus,
    output o_flush, o_stall, o_redirect_valid, o_redirect_pc, o_trap_taken
  );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap/MRET sequencer with mepc/mcause/mtval/mstatus
module trap_controller #(
  parameter int XLEN = 32
) (
  input logic             i_clk,
  input logic             i_rst,
  trap_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  logic [1:0]      state;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] target_q;
  logic            trap_taken_q;

  logic [2:0]      irq_pend;
  logic            take_irq;
  logic            take_exc;
  logic            take_mret;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] trap_target;

  // Only MEIE/MSIE/MTIE are consulted; the remaining mie bits are don't-care here.
  logic unused_mie_bits;
  assign unused_mie_bits = ^{bus.i_mie[XLEN-1:12], bus.i_mie[10:8], bus.i_mie[6:4], bus.i_mie[2:0]};

  // Decode the highest-priority event the EX instruction presents while idle.
  always_comb begin
    irq_pend    = {bus.i_meip & bus.i_mie[11], bus.i_msip & bus.i_mie[3], bus.i_mtip & bus.i_mie[7]};
    take_irq    = (state == ST_IDLE) && bus.i_ex_valid && mie_q && (irq_pend != 3'b000);
    take_exc    = (state == ST_IDLE) && bus.i_ex_valid && !take_irq && bus.i_exception_valid;
    take_mret   = (state == ST_IDLE) && bus.i_ex_valid && !take_irq && !bus.i_exception_valid
                  && bus.i_is_mret;
    irq_code    = irq_pend[2] ? 4'd11 : (irq_pend[1] ? 4'd3 : 4'd7);
    trap_cause  = take_irq ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : bus.i_exception_cause;
    vec_base    = {bus.i_mtvec[XLEN-1:2], 2'b00};
    trap_target = vec_base;
    if (take_irq && (bus.i_mtvec[1:0] == 2'b01)) begin
      trap_target = vec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    end
  end

  // FSM, trap/MRET commit and the CSR write port (commits take precedence over writes).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      target_q     <= '0;
      trap_taken_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          trap_taken_q <= 1'b0;
          if (take_irq || take_exc) begin
            mepc_q       <= {bus.i_ex_pc[XLEN-1:1], 1'b0};
            mcause_q     <= trap_cause;
            mtval_q      <= take_irq ? '0 : bus.i_exception_tval;
            mpie_q       <= mie_q;
            mie_q        <= 1'b0;
            target_q     <= trap_target;
            trap_taken_q <= 1'b1;
            state        <= ST_FLUSH;
          end else if (take_mret) begin
            mie_q    <= mpie_q;
            mpie_q   <= 1'b1;
            target_q <= mepc_q;
            state    <= ST_FLUSH;
          end else if (bus.i_csr_we) begin
            case (bus.i_csr_addr)
              CSR_MSTATUS: begin
                mie_q  <= bus.i_csr_wdata[3];
                mpie_q <= bus.i_csr_wdata[7];
              end
              CSR_MEPC:   mepc_q   <= {bus.i_csr_wdata[XLEN-1:1], 1'b0};
              CSR_MCAUSE: mcause_q <= bus.i_csr_wdata;
              CSR_MTVAL:  mtval_q  <= bus.i_csr_wdata;
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          trap_taken_q <= 1'b0;
          state        <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          trap_taken_q <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          trap_taken_q <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are register values or pure state decodes.
  always_comb begin
    bus.o_mepc           = mepc_q;
    bus.o_mcause         = mcause_q;
    bus.o_mtval          = mtval_q;
    bus.o_mstatus        = '0;
    bus.o_mstatus[3]     = mie_q;
    bus.o_mstatus[7]     = mpie_q;
    bus.o_flush          = (state == ST_FLUSH) || (state == ST_REDIRECT);
    bus.o_stall          = (state == ST_FLUSH) || (state == ST_REDIRECT);
    bus.o_redirect_valid = (state == ST_REDIRECT);
    bus.o_redirect_pc    = (state == ST_REDIRECT) ? target_q : '0;
    bus.o_trap_taken     = trap_taken_q;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Consumes the synchronous-exception report produced in the Execute stage (valid, cause, tval), plus `mret` and machine-level interrupt requests. Commits trap state into `mepc`/`mcause`/`mtval`/`mstatus.{MIE,MPIE}` and sequences the pipeline through a flush cycle and a redirect cycle to the trap vector or to `mepc`. Sits beside the EX stage and drives the front end's redirect port and the hazard unit's flush and stall inputs.

## Interface
- `XLEN`, 32, data and address width.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_ex_valid` in 1: EX holds a live, non-stalled instruction.
- `i_ex_pc` in XLEN: PC of the EX instruction.
- `i_exception_valid` in 1: synchronous exception on the EX instruction.
- `i_exception_cause` in XLEN: exception code, MSB = 0.
- `i_exception_tval` in XLEN: trap value.
- `i_is_mret` in 1: EX instruction is MRET.
- `i_meip`, `i_msip`, `i_mtip` in 1 each: level interrupt pending lines.
- `i_mie` in XLEN: `mie` CSR. Uses bits 11, 3 and 7.
- `i_mtvec` in XLEN: `mtvec`. Bits [1:0] are the mode: 0 = direct, 1 = vectored.
- `i_csr_we` in 1, `i_csr_addr` in 12, `i_csr_wdata` in XLEN: CSR write port for the EX instruction.
- `o_mepc`, `o_mcause`, `o_mtval`, `o_mstatus` out XLEN each: CSR read values. `o_mstatus` shows only bit 3 (MIE) and bit 7 (MPIE); all other bits read 0.
- `o_flush` out 1: kill IF/ID/EX contents.
- `o_stall` out 1: freeze PC and pipeline registers.
- `o_redirect_valid` out 1, `o_redirect_pc` out XLEN: front-end redirect.
- `o_trap_taken` out 1: one-cycle pulse when trap CSRs commit.

## Operation
- **States:**
  - IDLE → FLUSH on a trap event or on MRET.
  - FLUSH → REDIRECT unconditionally.
  - REDIRECT → IDLE unconditionally.
  - No event is sampled outside IDLE.
- **Event evaluation (IDLE, `i_ex_valid`=1), in priority order:**
  1. Interrupt, when `mstatus.MIE` and `(pending & i_mie)` ≠ 0. Among interrupts: MEI (cause 11) > MSI (3) > MTI (7). Interrupt cause = {1'b1, code}.
  2. Exception (`i_exception_valid`).
  3. MRET.
  - When an interrupt is taken, the EX instruction does not retire, even if it also raised an exception.
- **Trap commit (IDLE→FLUSH edge):**
  - `mepc` ← `i_ex_pc` with bit 0 cleared.
  - `mcause` ← cause.
  - `mtval` ← `i_exception_tval` for an exception, 0 for an interrupt.
  - MPIE ← MIE, then MIE ← 0.
  - Latch the target:
    - Direct mode, or any exception: {mtvec[XLEN-1:2], 2'b00}.
    - Vectored mode with an interrupt: that base + 4·code, modulo 2^XLEN.
- **MRET commit:**
  - MIE ← MPIE, MPIE ← 1.
  - Target ← current `mepc`.
  - No `o_trap_taken` pulse.
- **CSR writes**, applied only when `i_csr_we`:
  - Addresses: 0x300 (MIE, MPIE), 0x341 (`mepc`, bit 0 forced 0), 0x342, 0x343.
  - A trap or MRET commit in the same cycle wins, and the CSR write is dropped.
  - A CSR write that arrives while not in IDLE is ignored.
- **Reset:**
  - State IDLE.
  - All CSRs 0 (MIE = 0, MPIE = 0).
  - All outputs 0.
  - Latched target 0.

## Timing
- **Event at cycle T (sampled in IDLE):**
  - Cycle T+1 (FLUSH): `o_flush`=1, `o_stall`=1, `o_trap_taken`=1 for a trap. CSR outputs already show the new values.
  - Cycle T+2 (REDIRECT): `o_redirect_valid`=1 with `o_redirect_pc` = latched target, `o_stall`=1, `o_flush`=1.
  - Cycle T+3: IDLE, all strobes 0. The earliest next event is sampled at T+3.
- All outputs are registered or decoded from state only. There is no combinational path from the `i_exception_*` inputs to any output.
- Interrupt lines are levels. An interrupt still pending and enabled after MRET retraps in the first IDLE cycle with `i_ex_valid`.
- `i_rst` during FLUSH or REDIRECT returns to IDLE on the next edge. The redirect is abandoned and the CSRs are cleared.
- `i_ex_valid`=0 masks all events, including pending interrupts.

## Test plan
- **Misaligned load:** exception cause 4, tval 0x1001, PC 0x80, mtvec 0x200, MIE=1.
  - T+1: mepc 0x80, mcause 4, mtval 0x1001, MIE 0, MPIE 1, flush and trap_taken.
  - T+2: redirect to 0x200.
- **Vectored timer interrupt:** mtvec 0x301, MIE=1, mie bit 7 set, `i_mtip`=1, concurrent exception.
  - mcause 0x80000007, mtval 0, redirect to 0x31C.
  - The exception is ignored.
- **Interrupt priority and masking:**
  - All three lines pending with all enables set → cause code 11.
  - The same with MIE=0 → no trap, outputs idle.
- **MRET:** mepc 0x1234 (written via CSR 0x341), MPIE=1, MIE=0.
  - After MRET: MIE 1, MPIE 1, redirect 0x1234, no trap_taken pulse.
- **Back-to-back events:** second exception presented at T+1 and T+2 → ignored. Presented at T+3 → taken.
- **Contention and reset:**
  - CSR write to 0x342 in the same cycle as a trap → mcause holds the trap cause.
  - `i_rst` asserted at T+1 → T+2 shows no redirect and all CSRs are 0.
